// File: rtl/gecko_register_file_pkg.sv
// Shared types for the gecko integer register file: FSM state encoding and
// the RV32 register address/value types used by the default configuration.
package gecko_register_file_pkg;

  typedef enum logic {
    GECKO_REGFILE_RESET  = 1'b0,
    GECKO_REGFILE_NORMAL = 1'b1
  } gecko_regfile_state_t;

  localparam int RV32_XLEN       = 32;
  localparam int RV32_REG_ADDR_W = 5;

  typedef logic [RV32_REG_ADDR_W-1:0] rv32_reg_addr_t;
  typedef logic [RV32_XLEN-1:0]       rv32_reg_value_t;

endpackage

// File: rtl/gecko_register_file_if.sv
// Issue/writeback bus of the gecko register file. The master side is
// decode/issue plus the writeback units; the slave side is the register file.
interface gecko_register_file_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1
) ();

  logic                   ready;
  logic [ADDR_WIDTH-1:0]  read_addr   [READ_PORTS];
  logic [DATA_WIDTH-1:0]  read_data   [READ_PORTS];
  logic [READ_PORTS-1:0]  read_busy;
  logic [WRITE_PORTS-1:0] write_valid;
  logic [ADDR_WIDTH-1:0]  write_addr  [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]  write_data  [WRITE_PORTS];
  logic                   reserve_valid;
  logic [ADDR_WIDTH-1:0]  reserve_addr;

  modport master (
    input  ready, read_data, read_busy,
    output read_addr, write_valid, write_addr, write_data,
           reserve_valid, reserve_addr
  );

  modport slave (
    output ready, read_data, read_busy,
    input  read_addr, write_valid, write_addr, write_data,
           reserve_valid, reserve_addr
  );

endinterface

// File: rtl/gecko_register_scoreboard.sv
// Per-register busy scoreboard. Reservations (new producer issued) take
// priority over writeback clears to the same register in the same cycle.
module gecko_register_scoreboard #(
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   reserve_valid_i,
  input  logic [ADDR_WIDTH-1:0]  reserve_addr_i,
  input  logic [WRITE_PORTS-1:0] clear_valid_i,
  input  logic [ADDR_WIDTH-1:0]  clear_addr_i [WRITE_PORTS],
  input  logic [ADDR_WIDTH-1:0]  read_addr_i  [READ_PORTS],
  output logic [READ_PORTS-1:0]  read_busy_o
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy vector: clears from writeback first, then the reservation.
  always_comb begin
    busy_d = busy_q;
    if (enable_i) begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (clear_valid_i[w]) busy_d[clear_addr_i[w]] = 1'b0;
      end
      if (reserve_valid_i) busy_d[reserve_addr_i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy vector register, all idle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Busy lookup per read port; reported idle while the sweep runs.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      read_busy_o[r] = enable_i & busy_q[read_addr_i[r]];
    end
  end

endmodule

// File: rtl/gecko_register_file.sv
// gecko integer register file: N combinational read ports, M writeback ports,
// post-reset clearing sweep (one register per cycle) and busy scoreboard.
// Optional build macro GECKO_REGFILE_BYPASS_EN forwards same-cycle writeback
// data onto matching read ports; without it reads come from stored state only.
module gecko_register_file
  import gecko_register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 1,
  parameter int ZERO_REG    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  gecko_register_file_if.slave bus
);

  localparam int                    NUM_REGS  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  gecko_regfile_state_t  state_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  normal;
  logic [WRITE_PORTS-1:0] wr_en;

  assign normal    = (state_q == GECKO_REGFILE_NORMAL);
  assign bus.ready = ready_q;

  // Effective write strobes: only in NORMAL, never to a hardwired zero register.
  always_comb begin
    for (int w = 0; w < WRITE_PORTS; w++) begin
      wr_en[w] = normal && bus.write_valid[w] &&
                 !((ZERO_REG != 0) && (bus.write_addr[w] == '0));
    end
  end

  // Sweep FSM: walk every register once after reset, then stay in NORMAL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GECKO_REGFILE_RESET;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        GECKO_REGFILE_RESET: begin
          count_q <= count_q + 1'b1;
          if (count_q == LAST_ADDR) begin
            state_q <= GECKO_REGFILE_NORMAL;
            ready_q <= 1'b1;
          end
        end
        GECKO_REGFILE_NORMAL: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= GECKO_REGFILE_RESET;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset of its own: the sweep clears it. Later ports win.
  always_ff @(posedge clk) begin
    if (!normal) begin
      regs_q[count_q] <= '0;
    end else begin
      for (int w = 0; w < WRITE_PORTS; w++) begin
        if (wr_en[w]) regs_q[bus.write_addr[w]] <= bus.write_data[w];
      end
    end
  end

  // Combinational read ports, forced to zero during the sweep.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      bus.read_data[r] = '0;
      if (normal) begin
        bus.read_data[r] = regs_q[bus.read_addr[r]];
`ifdef GECKO_REGFILE_BYPASS_EN
        for (int w = 0; w < WRITE_PORTS; w++) begin
          if (wr_en[w] && (bus.write_addr[w] == bus.read_addr[r])) begin
            bus.read_data[r] = bus.write_data[w];
          end
        end
`endif
        if ((ZERO_REG != 0) && (bus.read_addr[r] == '0)) bus.read_data[r] = '0;
      end
    end
  end

  gecko_register_scoreboard #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_PORTS  (READ_PORTS),
    .WRITE_PORTS (WRITE_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_scoreboard (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (normal),
    .reserve_valid_i (bus.reserve_valid),
    .reserve_addr_i  (bus.reserve_addr),
    .clear_valid_i   (wr_en),
    .clear_addr_i    (bus.write_addr),
    .read_addr_i     (bus.read_addr),
    .read_busy_o     (bus.read_busy)
  );

endmodule

// File: tb/tb_gecko_register_file.sv
// Testbench for gecko_register_file: reset sweep timing, directed vector
// table, bypass behaviour, randomized traffic against an array model and
// reset in NORMAL with writes attempted mid-sweep.
module tb_gecko_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RP = 2;
  localparam int WP = 2;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gecko_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                           .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

  gecko_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_PORTS(RP),
                        .WRITE_PORTS(WP), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [NR];
  logic          m_busy [NR];

  typedef struct {
    string         name;
    logic [1:0]    wv;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          rv;
    logic [AW-1:0] ra;
    logic [AW-1:0] rd0;
    logic [AW-1:0] rd1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic          eb0;
    logic          eb1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.write_valid   = '0;
    bus.reserve_valid = 1'b0;
    bus.reserve_addr  = '0;
    for (int w = 0; w < WP; w++) begin
      bus.write_addr[w] = '0;
      bus.write_data[w] = '0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock edge in NORMAL: the model applies the driven writes (higher port
  // index last) and then the reservation, so reserve beats a same-cycle clear.
  task automatic tick();
    logic [DW-1:0] n_regs [NR];
    logic          n_busy [NR];
    n_regs = m_regs;
    n_busy = m_busy;
    for (int w = 0; w < WP; w++) begin
      if (bus.write_valid[w] && bus.write_addr[w] != 0) begin
        n_regs[bus.write_addr[w]] = bus.write_data[w];
        n_busy[bus.write_addr[w]] = 1'b0;
      end
    end
    if (bus.reserve_valid && bus.reserve_addr != 0) n_busy[bus.reserve_addr] = 1'b1;
    @(posedge clk);
    #1;
    m_regs = n_regs;
    m_busy = n_busy;
    drive_idle();
  endtask

  function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = m_regs[a];
`ifdef GECKO_REGFILE_BYPASS_EN
    for (int w = 0; w < WP; w++) begin
      if (bus.write_valid[w] && bus.write_addr[w] == a) v = bus.write_data[w];
    end
`endif
    if (a == 0) v = '0;
    return v;
  endfunction

  // Counts edges after rst deasserts until ready; returns 100 on timeout.
  task automatic wait_ready(output int cycles, input logic poke_writes);
    cycles = 0;
    while (cycles < 100) begin
      if (poke_writes) begin
        bus.write_valid   = 2'b11;
        bus.write_addr[0] = 5'd10;
        bus.write_data[0] = 32'h99;
        bus.write_addr[1] = 5'd4;
        bus.write_data[1] = 32'h55;
        bus.reserve_valid = 1'b1;
        bus.reserve_addr  = 5'd10;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 16) begin
        bus.read_addr[0] = 5'd10;
        #1;
        check("sweep_read_zero", bus.read_data[0], '0);
        check("sweep_busy_zero", {31'd0, bus.read_busy[0]}, '0);
      end
      if (bus.ready) break;
    end
  endtask

  initial begin
    int cyc;
    logic [DW-1:0] exp_now;

    vecs[0] = '{"wr_r5",        2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[1] = '{"wr_r0_drop",   2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd5,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2] = '{"dual_wr_r7",   2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       1'b0, 5'd0, 5'd7, 5'd7,  32'h22,       32'h22,       1'b0, 1'b0};
    vecs[3] = '{"reserve_r3",   2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd3, 5'd3, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0};
    vecs[4] = '{"wr_clears_r3", 2'b01, 5'd3,  32'h5,        5'd0,  32'h0,        1'b0, 5'd0, 5'd3, 5'd7,  32'h5,        32'h22,       1'b0, 1'b0};
    vecs[5] = '{"resv_and_wr",  2'b01, 5'd3,  32'h5,        5'd0,  32'h0,        1'b1, 5'd3, 5'd3, 5'd3,  32'h5,        32'h5,        1'b1, 1'b1};
    vecs[6] = '{"reserve_r0",   2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0, 5'd0, 5'd3,  32'h0,        32'h5,        1'b0, 1'b1};
    vecs[7] = '{"p1_wr_r3",     2'b10, 5'd0,  32'h0,        5'd3,  32'h6,        1'b0, 5'd0, 5'd3, 5'd0,  32'h6,        32'h0,        1'b0, 1'b0};
    vecs[8] = '{"two_regs",     2'b11, 5'd8,  32'hAAAA0000, 5'd9,  32'h0000BBBB, 1'b1, 5'd8, 5'd8, 5'd9,  32'hAAAA0000, 32'h0000BBBB, 1'b1, 1'b0};
    vecs[9] = '{"r8_and_r31",   2'b11, 5'd8,  32'h1,        5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd8, 5'd31, 32'h1,        32'hFFFFFFFF, 1'b0, 1'b0};

    rst = 1'b1;
    drive_idle();
    bus.read_addr[0] = '0;
    bus.read_addr[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, '0);
    check("rst_read_data", bus.read_data[0], '0);
    check("rst_read_busy", {30'd0, bus.read_busy}, '0);
    rst = 1'b0;

    wait_ready(cyc, 1'b0);
    check("sweep_cycles", cyc, 32);
    model_clear();
    for (int i = 0; i < NR; i++) begin
      bus.read_addr[0] = AW'(i);
      bus.read_addr[1] = AW'(NR - 1 - i);
      #1;
      check("post_sweep_p0", bus.read_data[0], '0);
      check("post_sweep_p1", bus.read_data[1], '0);
      check("post_sweep_busy", {30'd0, bus.read_busy}, '0);
    end

    for (int v = 0; v < 10; v++) begin
      bus.write_valid   = vecs[v].wv;
      bus.write_addr[0] = vecs[v].wa0;
      bus.write_data[0] = vecs[v].wd0;
      bus.write_addr[1] = vecs[v].wa1;
      bus.write_data[1] = vecs[v].wd1;
      bus.reserve_valid = vecs[v].rv;
      bus.reserve_addr  = vecs[v].ra;
      tick();
      bus.read_addr[0] = vecs[v].rd0;
      bus.read_addr[1] = vecs[v].rd1;
      #1;
      check({vecs[v].name, "_d0"}, bus.read_data[0], vecs[v].e0);
      check({vecs[v].name, "_d1"}, bus.read_data[1], vecs[v].e1);
      check({vecs[v].name, "_b0"}, {31'd0, bus.read_busy[0]}, {31'd0, vecs[v].eb0});
      check({vecs[v].name, "_b1"}, {31'd0, bus.read_busy[1]}, {31'd0, vecs[v].eb1});
    end

    // Same-cycle read of a register being written (r9 holds 0x0000BBBB).
    bus.write_valid   = 2'b11;
    bus.write_addr[0] = 5'd9;
    bus.write_data[0] = 32'hA5A5A5A5;
    bus.write_addr[1] = 5'd0;
    bus.write_data[1] = 32'h1234;
    bus.read_addr[0]  = 5'd9;
    bus.read_addr[1]  = 5'd0;
    #1;
`ifdef GECKO_REGFILE_BYPASS_EN
    exp_now = 32'hA5A5A5A5;
`else
    exp_now = 32'h0000BBBB;
`endif
    check("same_cycle_r9", bus.read_data[0], exp_now);
    check("same_cycle_r0", bus.read_data[1], '0);
    tick();
    #1;
    check("next_cycle_r9", bus.read_data[0], 32'hA5A5A5A5);

    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < WP; w++) begin
        bus.write_valid[w] = 1'($urandom_range(0, 1));
        bus.write_addr[w]  = AW'($urandom_range(0, NR - 1));
        bus.write_data[w]  = $urandom;
      end
      if ($urandom_range(0, 3) == 0) bus.write_addr[1] = bus.write_addr[0];
      bus.reserve_valid = 1'($urandom_range(0, 1));
      bus.reserve_addr  = ($urandom_range(0, 2) == 0) ? bus.write_addr[0]
                                                        : AW'($urandom_range(0, NR - 1));
      for (int r = 0; r < RP; r++) bus.read_addr[r] = AW'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 2) == 0) bus.read_addr[0] = bus.write_addr[1];
      #1;
      for (int r = 0; r < RP; r++) begin
        check("rand_data", bus.read_data[r], expect_rd(bus.read_addr[r]));
        check("rand_busy", {31'd0, bus.read_busy[r]}, {31'd0, m_busy[bus.read_addr[r]]});
      end
      tick();
    end

    // Reset while in NORMAL, then writes and reserves hammered during the sweep.
    bus.write_valid   = 2'b01;
    bus.write_addr[0] = 5'd10;
    bus.write_data[0] = 32'h77;
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd4;
    tick();
    bus.read_addr[0] = 5'd10;
    bus.read_addr[1] = 5'd4;
    #1;
    check("pre_rst_r10", bus.read_data[0], 32'h77);
    check("pre_rst_busy_r4", {31'd0, bus.read_busy[1]}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst2_ready", {31'd0, bus.ready}, '0);
    check("rst2_data", bus.read_data[0], '0);
    check("rst2_busy", {30'd0, bus.read_busy}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ready(cyc, 1'b1);
    check("resweep_cycles", cyc, 32);
    drive_idle();
    model_clear();
    bus.read_addr[0] = 5'd10;
    bus.read_addr[1] = 5'd4;
    #1;
    check("resweep_r10", bus.read_data[0], '0);
    check("resweep_r4", bus.read_data[1], '0);
    check("resweep_busy", {30'd0, bus.read_busy}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
